// File: rtl/rgy_pkg.sv
// Shared types and constants for the RGY phase timer: colour codes, the
// timer FSM encoding and the one-hot legality check on the light bus.
package rgy_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  typedef enum logic [2:0] {LOAD, COUNT, ADV, WAIT_CHG, FAULT} phase_state_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == RED) || (v == GREEN) || (v == YELLOW);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter for phase dwell time; holds at zero instead of wrapping.
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/rgy_phase_timer.sv
// Dwell timer ahead of the RGY sequencer: times each colour, pulses advance,
// extends red for latched pedestrian requests and traps illegal light codes.
module rgy_phase_timer
  import rgy_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int RED_T     = 20,
  parameter int GREEN_T   = 15,
  parameter int YEL_T     = 3,
  parameter int PED_EXTRA = 10,
  parameter int WAIT_MAX  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_en,
  input  logic [2:0]       light,
  input  logic             ped_req,
  output logic             advance,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_ack,
  output logic             ped_walk,
  output logic             fault,
  output phase_state_t     dbg_state
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int RED_EXT = (RED_T + PED_EXTRA > CNT_MAX) ? CNT_MAX : (RED_T + PED_EXTRA);
  localparam int WW      = $clog2(WAIT_MAX + 1);

  phase_state_t     state_q, state_d;
  logic [2:0]       cur_light_q, cur_light_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             advance_q, advance_d;
  logic             ped_ack_q, ped_ack_d;
  logic             ped_walk_q, ped_walk_d;
  logic             ped_pend_q, ped_pend_d;
  logic             fault_q, fault_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_count;

  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cur_light_d  = cur_light_q;
    wait_d       = wait_q;
    advance_d    = 1'b0;
    ped_ack_d    = 1'b0;
    ped_walk_d   = ped_walk_q;
    ped_pend_d   = ped_pend_q;
    fault_d      = fault_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    // A request is only taken when nothing is queued or being served.
    if (ped_req && !ped_pend_q && !ped_walk_q && (state_q != FAULT)) begin
      ped_pend_d = 1'b1;
      ped_ack_d  = 1'b1;
    end

    case (state_q)
      LOAD: begin
        cur_light_d = light;
        cnt_load    = 1'b1;
        ped_walk_d  = 1'b0;
        if (light == GREEN) begin
          cnt_load_val = CNT_W'(GREEN_T);
        end else if (light == YELLOW) begin
          cnt_load_val = CNT_W'(YEL_T);
        end else if (ped_pend_q) begin
          cnt_load_val = CNT_W'(RED_EXT);
          ped_walk_d   = 1'b1;
          ped_pend_d   = 1'b0;
        end else begin
          cnt_load_val = CNT_W'(RED_T);
        end
        state_d = COUNT;
      end
      COUNT: begin
        // A colour change we did not ask for restarts timing for the new colour.
        if (light != cur_light_q) begin
          state_d = LOAD;
        end else if (tick_en && !cnt_zero) begin
          cnt_dec = 1'b1;
          if (cnt_count == CNT_W'(1)) begin
            state_d    = ADV;
            advance_d  = 1'b1;
            ped_walk_d = 1'b0;
          end
        end
      end
      ADV: begin
        ped_walk_d = 1'b0;
        wait_d     = '0;
        state_d    = WAIT_CHG;
      end
      WAIT_CHG: begin
        if (light != cur_light_q) begin
          state_d = LOAD;
        end else if (wait_q == WW'(WAIT_MAX - 1)) begin
          state_d = FAULT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = FAULT;
    endcase

    if ((state_q != FAULT) && !is_onehot3(light)) begin
      state_d = FAULT;
    end

    if (state_d == FAULT) begin
      fault_d      = 1'b1;
      advance_d    = 1'b0;
      ped_ack_d    = 1'b0;
      ped_walk_d   = 1'b0;
      ped_pend_d   = ped_pend_q;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cur_light_q <= RED;
      wait_q      <= '0;
      advance_q   <= 1'b0;
      ped_ack_q   <= 1'b0;
      ped_walk_q  <= 1'b0;
      ped_pend_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_light_q <= cur_light_d;
      wait_q      <= wait_d;
      advance_q   <= advance_d;
      ped_ack_q   <= ped_ack_d;
      ped_walk_q  <= ped_walk_d;
      ped_pend_q  <= ped_pend_d;
      fault_q     <= fault_d;
    end
  end

  assign advance   = advance_q;
  assign remaining = cnt_count;
  assign ped_ack   = ped_ack_q;
  assign ped_walk  = ped_walk_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rgy_phase_timer.sv
// Directed bench for rgy_phase_timer with a three-colour sequencer model
// stepped by advance; a second instance checks red-extension saturation.
module tb_rgy_phase_timer;
  import rgy_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         tick_en;
  logic [2:0]   light;
  logic         ped_req;
  logic         advance, ped_ack, ped_walk, fault;
  logic [7:0]   remaining;
  phase_state_t dbg_state;
  logic         advance2, ped_ack2, ped_walk2, fault2;
  logic [7:0]   remaining2;
  phase_state_t dbg_state2;

  int vec_cnt = 0;
  int err_cnt = 0;
  int adv_total = 0;
  int ack_total = 0;
  int phase_ticks = 0;
  int ped_hold_left = 0;
  bit seq_en = 1'b1;
  bit adv_seen_prev = 1'b0;
  phase_state_t pre_state;
  logic         pre_tick;
  logic [7:0]   pre_rem;

  rgy_phase_timer dut (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .light(light), .ped_req(ped_req),
    .advance(advance), .remaining(remaining), .ped_ack(ped_ack), .ped_walk(ped_walk),
    .fault(fault), .dbg_state(dbg_state)
  );

  rgy_phase_timer #(.PED_EXTRA(250)) dut_sat (
    .clk(clk), .rst_n(rst_n), .tick_en(tick_en), .light(light), .ped_req(ped_req),
    .advance(advance2), .remaining(remaining2), .ped_ack(ped_ack2), .ped_walk(ped_walk2),
    .fault(fault2), .dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] next_light(input logic [2:0] l);
    if (l == RED) return GREEN;
    if (l == GREEN) return YELLOW;
    return RED;
  endfunction

  // One clock: sample pre-edge context, step the sequencer model, drive inputs.
  task automatic cyc();
    pre_state = dbg_state;
    pre_tick  = tick_en;
    pre_rem   = remaining;
    @(posedge clk);
    #1;
    if (pre_state == COUNT && pre_tick) phase_ticks++;
    if (seq_en && adv_seen_prev) light = next_light(light);
    adv_seen_prev = advance;
    if (advance) adv_total++;
    if (ped_ack) ack_total++;
    tick_en = ~tick_en;
    if (ped_hold_left > 0) begin
      ped_req = 1'b1;
      ped_hold_left--;
    end else begin
      ped_req = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    light = RED;
    ped_req = 1'b0;
    ped_hold_left = 0;
    tick_en = 1'b0;
    adv_seen_prev = 1'b0;
    seq_en = 1'b1;
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  // Runs one phase from COUNT entry to its advance pulse (ending on the ADV sample).
  task automatic run_phase(input string name, input int exp_load, input bit exp_walk,
                           input int ped_at, input int ped_len, input bit chk_sat);
    int n;
    bit walk_bad;
    n = 0;
    while (dbg_state != COUNT && n < 20) begin
      cyc();
      n++;
    end
    vec_cnt++;
    if (dbg_state !== COUNT) begin
      err_cnt++;
      $display("FAIL %s_enter: state=%0d required COUNT", name, dbg_state);
      return;
    end
    vec_cnt++;
    if (remaining !== 8'(exp_load)) begin
      err_cnt++;
      $display("FAIL %s_load: remaining=%0d required %0d", name, remaining, exp_load);
    end
    vec_cnt++;
    if (ped_walk !== exp_walk) begin
      err_cnt++;
      $display("FAIL %s_walk_start: ped_walk=%0b required %0b", name, ped_walk, exp_walk);
    end
    if (chk_sat) begin
      vec_cnt++;
      if (remaining2 !== 8'd255 || ped_walk2 !== 1'b1) begin
        err_cnt++;
        $display("FAIL %s_saturate: remaining=%0d walk=%0b required 255/1", name, remaining2, ped_walk2);
      end
    end
    phase_ticks = 0;
    walk_bad = 1'b0;
    n = 0;
    while (!advance && n < 700) begin
      if (dbg_state == COUNT && ped_walk !== exp_walk) walk_bad = 1'b1;
      if (n == ped_at && ped_len > 0) ped_hold_left = ped_len;
      cyc();
      n++;
    end
    vec_cnt++;
    if (advance !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s_advance_timeout: advance=%0b required 1", name, advance);
      return;
    end
    vec_cnt++;
    if (phase_ticks != exp_load) begin
      err_cnt++;
      $display("FAIL %s_ticks: got %0d ticks required %0d", name, phase_ticks, exp_load);
    end
    vec_cnt++;
    if (pre_rem !== 8'd1 || pre_tick !== 1'b1 || remaining !== 8'd0) begin
      err_cnt++;
      $display("FAIL %s_latency: prev_rem=%0d prev_tick=%0b rem=%0d required 1/1/0",
               name, pre_rem, pre_tick, remaining);
    end
    vec_cnt++;
    if (walk_bad || ped_walk !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s_walk: walk_bad=%0b walk_at_adv=%0b required 0/0", name, walk_bad, ped_walk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    light = RED;
    ped_req = 1'b0;
    tick_en = 1'b0;
    #1;
    vec_cnt++;
    if ({advance, ped_ack, ped_walk, fault} !== 4'b0 || remaining !== 8'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: adv/ack/walk/fault=%b rem=%0d required 0000/0",
               {advance, ped_ack, ped_walk, fault}, remaining);
    end
    do_reset();
    vec_cnt++;
    if (dbg_state !== LOAD || remaining !== 8'd0) begin
      err_cnt++;
      $display("FAIL reset_release: state=%0d rem=%0d required LOAD/0", dbg_state, remaining);
    end
  endtask

  task automatic test_first_phase();
    run_phase("red0", 20, 1'b0, -1, 0, 1'b0);
    run_phase("green0", 15, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_full_cycle();
    int adv_base, ack_base;
    adv_base = adv_total;
    ack_base = ack_total;
    run_phase("yel1", 3, 1'b0, -1, 0, 1'b0);
    run_phase("red1", 20, 1'b0, -1, 0, 1'b0);
    run_phase("green1", 15, 1'b0, -1, 0, 1'b0);
    vec_cnt++;
    if (adv_total - adv_base != 3 || ack_total != ack_base) begin
      err_cnt++;
      $display("FAIL full_cycle_counts: advances=%0d acks=%0d required 3/0",
               adv_total - adv_base, ack_total - ack_base);
    end
  endtask

  task automatic test_ped_pulse();
    int ack_base;
    run_phase("yel2", 3, 1'b0, -1, 0, 1'b0);
    run_phase("red2", 20, 1'b0, -1, 0, 1'b0);
    ack_base = ack_total;
    run_phase("green2", 15, 1'b0, 4, 1, 1'b0);
    vec_cnt++;
    if (ack_total - ack_base != 1) begin
      err_cnt++;
      $display("FAIL ped_pulse_ack: ack_cycles=%0d required 1", ack_total - ack_base);
    end
    run_phase("yel3", 3, 1'b0, -1, 0, 1'b0);
    run_phase("red3_ext", 30, 1'b1, -1, 0, 1'b1);
    run_phase("green3", 15, 1'b0, -1, 0, 1'b0);
    run_phase("yel4", 3, 1'b0, -1, 0, 1'b0);
    run_phase("red4", 20, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_ped_hold();
    int ack_base;
    run_phase("green5", 15, 1'b0, -1, 0, 1'b0);
    run_phase("yel5", 3, 1'b0, -1, 0, 1'b0);
    ack_base = ack_total;
    run_phase("red5_req", 20, 1'b0, 2, 100, 1'b0);
    run_phase("green6", 15, 1'b0, -1, 0, 1'b0);
    run_phase("yel6", 3, 1'b0, -1, 0, 1'b0);
    run_phase("red6_ext", 30, 1'b1, -1, 0, 1'b0);
    vec_cnt++;
    if (ack_total - ack_base != 1) begin
      err_cnt++;
      $display("FAIL ped_hold_single_ack: acks=%0d required 1", ack_total - ack_base);
    end
    run_phase("green7", 15, 1'b0, 3, 1, 1'b0);
    vec_cnt++;
    if (ack_total - ack_base != 2) begin
      err_cnt++;
      $display("FAIL ped_reack: acks=%0d required 2", ack_total - ack_base);
    end
    run_phase("yel7", 3, 1'b0, -1, 0, 1'b0);
    run_phase("red7_ext", 30, 1'b1, -1, 0, 1'b0);
  endtask

  task automatic test_illegal_light();
    bit stuck_bad;
    do_reset();
    repeat (6) cyc();
    light = 3'b011;
    cyc();
    vec_cnt++;
    if (fault !== 1'b1 || advance !== 1'b0 || ped_walk !== 1'b0 || remaining !== 8'd0) begin
      err_cnt++;
      $display("FAIL illegal_fault: fault=%0b adv=%0b walk=%0b rem=%0d required 1/0/0/0",
               fault, advance, ped_walk, remaining);
    end
    stuck_bad = 1'b0;
    light = RED;
    repeat (30) begin
      cyc();
      if (fault !== 1'b1 || advance !== 1'b0 || remaining !== 8'd0) stuck_bad = 1'b1;
    end
    vec_cnt++;
    if (stuck_bad) begin
      err_cnt++;
      $display("FAIL fault_sticky: left fault or pulsed advance, now fault=%0b adv=%0b", fault, advance);
    end
    do_reset();
    vec_cnt++;
    if (fault !== 1'b0 || dbg_state !== LOAD) begin
      err_cnt++;
      $display("FAIL fault_recover: fault=%0b state=%0d required 0/LOAD", fault, dbg_state);
    end
    run_phase("red_recover", 20, 1'b0, -1, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_reset();
    seq_en = 1'b0;
    run_phase("red_stuck", 20, 1'b0, -1, 0, 1'b0);
    repeat (4) cyc();
    vec_cnt++;
    if (fault !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_early: fault=%0b required 0 after 4 clk in WAIT_CHG", fault);
    end
    cyc();
    vec_cnt++;
    if (fault !== 1'b1 || fault2 !== 1'b1 || advance !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_fault: fault=%0b fault2=%0b adv=%0b required 1/1/0", fault, fault2, advance);
    end
    seq_en = 1'b1;
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (8) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({advance, ped_ack, ped_walk, fault, advance2, ped_ack2, ped_walk2, fault2} !== 8'b0 ||
        remaining !== 8'd0 || remaining2 !== 8'd0 || dbg_state !== LOAD || dbg_state2 !== LOAD) begin
      err_cnt++;
      $display("FAIL async_reset: flags=%b rem=%0d rem2=%0d state=%0d required 0/0/0/LOAD",
               {advance, ped_ack, ped_walk, fault, advance2, ped_ack2, ped_walk2, fault2},
               remaining, remaining2, dbg_state);
    end
    cyc();
    rst_n = 1'b1;
    run_phase("red_after_async", 20, 1'b0, -1, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_phase();
    test_full_cycle();
    test_ped_pulse();
    test_ped_hold();
    test_illegal_light();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
